// File: rtl/btn_hold_if.sv
// Button-conditioning bundle: raw button in, debounced level, press events and press count out.
interface btn_hold_if #(
   parameter int unsigned CNT_W = 8
);
   logic             btn_in;
   logic             btn_level;
   logic             press_pulse;
   logic             short_press;
   logic             long_press;
   logic             long_held;
   logic [CNT_W-1:0] press_count;

   modport master (
      output btn_in,
      input  btn_level, press_pulse, short_press, long_press, long_held, press_count
   );

   modport slave (
      input  btn_in,
      output btn_level, press_pulse, short_press, long_press, long_held, press_count
   );
endinterface

// File: rtl/btn_hold_detector.sv
// Synchronises and debounces the push button, times the hold and classifies each press as
// short or long. long_held selects the fast LED blink rate downstream.
//
// state | meaning
// IDLE  | debounced button released, waiting for a press
// HELD  | pressed, hold timer running toward the long-press threshold
// LONG  | long press declared, long_held asserted until release
module btn_hold_detector #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_250_000,
   parameter int unsigned LONG_CYCLES     = 125_000_000,
   parameter int unsigned CNT_W           = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   btn_hold_if.slave  bus
);
   localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
   localparam logic [DEB_W-1:0]  DEB_LOAD  = DEB_W'(DEBOUNCE_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(LONG_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;

   state_t             state_q, state_d;
   logic               s1_q, s1_d;
   logic               btn_s_q, btn_s_d;
   logic               level_q, level_d;
   logic [DEB_W-1:0]   deb_q, deb_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic               press_pulse_q, press_pulse_d;
   logic               short_press_q, short_press_d;
   logic               long_press_q, long_press_d;
   logic               long_held_q, long_held_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               rise, fall;

   // Down-counters: the debounce timer needs DEBOUNCE_CYCLES+1 mismatching cycles to accept a
   // new level; the hold timer hits terminal count LONG_CYCLES edges after the rise.
   always_comb begin
      s1_d    = bus.btn_in;
      btn_s_d = s1_q;
      level_d = level_q;
      deb_d   = DEB_LOAD;
      if (btn_s_q != level_q) begin
         if (deb_q == '0) begin
            level_d = btn_s_q;
         end else begin
            deb_d = deb_q - DEB_W'(1);
         end
      end
      rise = level_d & ~level_q;
      fall = ~level_d & level_q;
   end

   always_comb begin
      state_d       = state_q;
      hold_d        = hold_q;
      count_d       = count_q;
      press_pulse_d = 1'b0;
      short_press_d = 1'b0;
      long_press_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (rise) begin
               state_d       = HELD;
               press_pulse_d = 1'b1;
               count_d       = count_q + CNT_W'(1);
               hold_d        = HOLD_LOAD;
            end
         end
         HELD: begin
            // A release landing on the threshold edge is still a short press.
            if (fall) begin
               state_d       = IDLE;
               short_press_d = 1'b1;
            end else if (hold_q == '0) begin
               state_d      = LONG;
               long_press_d = 1'b1;
            end else begin
               hold_d = hold_q - HOLD_W'(1);
            end
         end
         LONG: begin
            if (fall) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      long_held_d = (state_d == LONG);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         s1_q          <= 1'b0;
         btn_s_q       <= 1'b0;
         level_q       <= 1'b0;
         deb_q         <= '0;
         hold_q        <= '0;
         press_pulse_q <= 1'b0;
         short_press_q <= 1'b0;
         long_press_q  <= 1'b0;
         long_held_q   <= 1'b0;
         count_q       <= '0;
      end else begin
         state_q       <= state_d;
         s1_q          <= s1_d;
         btn_s_q       <= btn_s_d;
         level_q       <= level_d;
         deb_q         <= deb_d;
         hold_q        <= hold_d;
         press_pulse_q <= press_pulse_d;
         short_press_q <= short_press_d;
         long_press_q  <= long_press_d;
         long_held_q   <= long_held_d;
         count_q       <= count_d;
      end
   end

   assign bus.btn_level   = level_q;
   assign bus.press_pulse = press_pulse_q;
   assign bus.short_press = short_press_q;
   assign bus.long_press  = long_press_q;
   assign bus.long_held   = long_held_q;
   assign bus.press_count = count_q;
endmodule

// File: tb/tb_btn_hold_detector.sv
// Directed bench for btn_hold_detector with short debounce/long thresholds.
module tb_btn_hold_detector;
   localparam int unsigned DEB   = 4;
   localparam int unsigned LONGC = 20;
   localparam int unsigned CW    = 2;

   typedef struct {
      logic       btn;
      logic       lvl;
      logic       pp;
      logic       sp;
      logic       lp;
      logic       lh;
      logic [1:0] cnt;
   } vec_t;

   logic clk;
   logic reset_n;
   int   checks   = 0;
   int   failures = 0;
   int   n_pp = 0, n_sp = 0, n_lp = 0;
   vec_t vecs[$];

   btn_hold_if #(.CNT_W(CW)) bus ();

   btn_hold_detector #(
      .DEBOUNCE_CYCLES(DEB),
      .LONG_CYCLES    (LONGC),
      .CNT_W          (CW)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      n_pp += int'(bus.press_pulse);
      n_sp += int'(bus.short_press);
      n_lp += int'(bus.long_press);
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0:       return bus.press_pulse;
         1:       return bus.long_press;
         default: return ~bus.long_held;
      endcase
   endfunction

   // Index of the edge (0 = first edge stepped) on which the selected output is seen; -1 on timeout.
   task automatic wait_sig(input int sel, input int max, output int edge_idx);
      edge_idx = -1;
      for (int i = 0; i < max; i++) begin
         step();
         if (sig(sel)) begin
            edge_idx = i;
            break;
         end
      end
   endtask

   function automatic void add(input int n, input logic btn, input logic lvl, input logic pp,
                               input logic sp, input logic lp, input logic lh, input logic [1:0] cnt);
      for (int i = 0; i < n; i++) vecs.push_back('{btn, lvl, pp, sp, lp, lh, cnt});
   endfunction

   function automatic int outs();
      return int'({bus.btn_level, bus.press_pulse, bus.short_press, bus.long_press,
                   bus.long_held, bus.press_count});
   endfunction

   initial begin
      int e, pp0, sp0, lp0;
      vec_t v;

      // glitch of 3 cycles: nothing changes
      add(3, 1, 0, 0, 0, 0, 0, 2'd0);
      add(5, 0, 0, 0, 0, 0, 0, 2'd0);
      // clean short press: rise on edge 6, release sampled at edge 10 -> fall on edge 16
      add(6, 1, 0, 0, 0, 0, 0, 2'd0);
      add(1, 1, 1, 1, 0, 0, 0, 2'd1);
      add(3, 1, 1, 0, 0, 0, 0, 2'd1);
      add(6, 0, 1, 0, 0, 0, 0, 2'd1);
      add(1, 0, 0, 0, 1, 0, 0, 2'd1);
      add(2, 0, 0, 0, 0, 0, 0, 2'd1);

      reset_n    = 1'b0;
      bus.btn_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", outs(), 0);
      reset_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         bus.btn_in = v.btn;
         step();
         chk($sformatf("vec%0d", i), outs(),
             int'({v.lvl, v.pp, v.sp, v.lp, v.lh, v.cnt}));
      end

      // long press
      sp0 = n_sp;
      bus.btn_in = 1'b1;
      wait_sig(0, 20, e);
      chk("long_rise_latency", e, 6);
      chk("long_count", int'(bus.press_count), 2);
      wait_sig(1, 40, e);
      chk("long_latency", e + 1, 20);
      chk("long_held_set", int'(bus.long_held), 1);
      step();
      chk("long_pulse_width", int'({bus.long_press, bus.long_held}), 1);
      repeat (5) step();
      bus.btn_in = 1'b0;
      wait_sig(2, 20, e);
      chk("long_release_latency", e, 6);
      repeat (3) step();
      chk("long_no_short", n_sp - sp0, 0);

      // release lands on the threshold edge
      sp0 = n_sp;
      lp0 = n_lp;
      bus.btn_in = 1'b1;
      repeat (20) step();
      bus.btn_in = 1'b0;
      repeat (12) step();
      chk("race_short", n_sp - sp0, 1);
      chk("race_long", n_lp - lp0, 0);
      chk("race_count", int'(bus.press_count), 3);

      // fourth press wraps the count, then reset mid-LONG
      bus.btn_in = 1'b1;
      wait_sig(0, 20, e);
      chk("wrap_rise_latency", e, 6);
      chk("wrap_count", int'(bus.press_count), 0);
      wait_sig(1, 40, e);
      chk("wrap_long_latency", e + 1, 20);
      step();
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_reset_outputs", outs(), 0);
      repeat (2) step();
      reset_n = 1'b1;
      wait_sig(0, 20, e);
      chk("post_reset_rise_latency", e, 6);
      chk("post_reset_count", int'(bus.press_count), 1);
      bus.btn_in = 1'b0;
      repeat (12) step();

      // bounce train then steady press
      pp0 = n_pp;
      for (int i = 0; i < 20; i++) begin
         bus.btn_in = ~i[0];
         repeat (2) step();
      end
      bus.btn_in = 1'b1;
      repeat (15) step();
      chk("bounce_presses", n_pp - pp0, 1);
      chk("bounce_count", int'(bus.press_count), 2);
      sp0 = n_sp;
      bus.btn_in = 1'b0;
      repeat (12) step();
      chk("bounce_short", n_sp - sp0, 1);
      chk("final_level", int'(bus.btn_level), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
